// File: rtl/key_event_queue.sv
// key_event_queue
//
// Turns a full multi-key keyboard report (NUM_KEYS keycode slots, code 0 = empty)
// into discrete press/release events. Each new report is diffed slot by slot
// against the previous one: all releases in slot order, then all presses in slot
// order. Events go into a first-word-fall-through FIFO. A report strobed while a
// scan is running is parked in a single pending buffer (latest wins) and scanned
// straight after the current one.
//
// Optional feature (macro KEY_EVT_REPEAT_EN): typematic repeat of the most recently
// pressed key. Once REPEAT_DELAY cycles have passed since that press, a press event
// with evt_repeat=1 is pushed, and then another one every REPEAT_RATE cycles, until
// a release of that key is scanned. Without the macro there is no timer and
// evt_repeat is tied low.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset (synchronous release expected)
//   report_in      keycode report, slot i at [i*KEY_W +: KEY_W]
//   report_wr      one-cycle strobe, report_in valid
//   busy           diff scan in progress
//   evt_valid      FIFO non-empty
//   evt_code       head event keycode (0 when empty)
//   evt_press      head event is a press (0 = release, 0 when empty)
//   evt_repeat     head event is a typematic repeat (0 when empty)
//   evt_ready      pop the head when evt_valid is also high
//   count          number of events held, 0..DEPTH
//   overflow       sticky: an event was dropped on a full FIFO
//   ovf_clr        clears overflow (a simultaneous drop wins)

module key_event_queue #(
    parameter int unsigned KEY_W        = 8,
    parameter int unsigned NUM_KEYS     = 6,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [NUM_KEYS*KEY_W-1:0]   report_in,
    input  logic                        report_wr,
    output logic                        busy,
    output logic                        evt_valid,
    output logic [KEY_W-1:0]            evt_code,
    output logic                        evt_press,
    output logic                        evt_repeat,
    input  logic                        evt_ready,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || KEY_W == 0 || NUM_KEYS == 0 ||
        REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_param_check
        $error("key_event_queue: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StRel, StPrs, StDone} state_e;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [KEY_W-1:0] cur_q  [NUM_KEYS];
    logic [KEY_W-1:0] prev_q [NUM_KEYS];
    logic [KEY_W-1:0] pend_q [NUM_KEYS];
    logic             pend_valid_q;

    logic [KEY_W-1:0] prev_sel, cur_sel;
    logic             rel_in_cur, rel_dup, prs_in_prev, prs_dup;
    logic             rel_hit, prs_hit;

    logic             scan_push;
    logic [KEY_W-1:0] scan_code;
    logic             scan_press;

    // Slot comparison for the slot currently under the index. A code repeated in
    // several slots only counts at its lowest slot.
    always_comb begin
        prev_sel    = prev_q[idx_q];
        cur_sel     = cur_q[idx_q];
        rel_in_cur  = 1'b0;
        rel_dup     = 1'b0;
        prs_in_prev = 1'b0;
        prs_dup     = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (cur_q[j] == prev_sel) rel_in_cur = 1'b1;
            if (prev_q[j] == cur_sel) prs_in_prev = 1'b1;
            if (IDX_W'(j) < idx_q) begin
                if (prev_q[j] == prev_sel) rel_dup = 1'b1;
                if (cur_q[j] == cur_sel) prs_dup = 1'b1;
            end
        end
        rel_hit = (prev_sel != '0) && !rel_in_cur && !rel_dup;
        prs_hit = (cur_sel != '0) && !prs_in_prev && !prs_dup;
    end

    always_comb begin
        scan_push  = 1'b0;
        scan_code  = '0;
        scan_press = 1'b0;
        if (state_q == StRel && rel_hit) begin
            scan_push = 1'b1;
            scan_code = prev_sel;
        end else if (state_q == StPrs && prs_hit) begin
            scan_push  = 1'b1;
            scan_code  = cur_sel;
            scan_press = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cur_q        <= '{default: '0};
            prev_q       <= '{default: '0};
            pend_q       <= '{default: '0};
            pend_valid_q <= 1'b0;
        end else begin
            // Strobes during the slot walk park in the pending buffer; a strobe in
            // the final cycle is taken directly as the next report instead.
            if (report_wr && (state_q == StRel || state_q == StPrs)) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    pend_q[i] <= report_in[i*KEY_W +: KEY_W];
                end
                pend_valid_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (report_wr) begin
                        for (int i = 0; i < NUM_KEYS; i++) begin
                            cur_q[i] <= report_in[i*KEY_W +: KEY_W];
                        end
                        idx_q   <= '0;
                        state_q <= StRel;
                    end
                end
                StRel: begin
                    if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                        idx_q   <= '0;
                        state_q <= StPrs;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StPrs: begin
                    if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                        idx_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    prev_q <= cur_q;
                    idx_q  <= '0;
                    if (report_wr) begin
                        for (int i = 0; i < NUM_KEYS; i++) begin
                            cur_q[i] <= report_in[i*KEY_W +: KEY_W];
                        end
                        pend_valid_q <= 1'b0;
                        state_q      <= StRel;
                    end else if (pend_valid_q) begin
                        cur_q        <= pend_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= StRel;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Push source selection (scan events always take priority)
    // ------------------------------------------------------------------
    logic             push_req;
    logic [KEY_W-1:0] push_code;
    logic             push_press;
    logic             push_ok;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] mem_code  [DEPTH];
    logic             mem_press [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q;
    logic             full, empty, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = evt_ready && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem_code[wr_ptr_q]  <= push_code;
            mem_press[wr_ptr_q] <= push_press;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            // Only scan events flag overflow; a new drop beats ovf_clr.
            if (scan_push && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign evt_valid = !empty;
    assign evt_code  = empty ? '0 : mem_code[rd_ptr_q];
    assign evt_press = empty ? 1'b0 : mem_press[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;

`ifdef KEY_EVT_REPEAT_EN
    // ------------------------------------------------------------------
    // Typematic repeat
    // ------------------------------------------------------------------
    logic             mem_rpt [DEPTH];
    logic             rpt_active_q;
    logic [KEY_W-1:0] rpt_code_q;
    logic [31:0]      rpt_timer_q;
    logic             rpt_fire;

    // Timer sitting at zero while the scan owns the push port simply waits a cycle.
    assign rpt_fire   = rpt_active_q && (rpt_timer_q == '0) && !scan_push;
    assign push_req   = scan_push || rpt_fire;
    assign push_code  = scan_push ? scan_code : rpt_code_q;
    assign push_press = scan_push ? scan_press : 1'b1;

    always_ff @(posedge clk_clk) begin
        if (push_ok) mem_rpt[wr_ptr_q] <= !scan_push;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rpt_active_q <= 1'b0;
            rpt_code_q   <= '0;
            rpt_timer_q  <= '0;
        end else begin
            if (scan_push && scan_press && push_ok) begin
                rpt_active_q <= 1'b1;
                rpt_code_q   <= scan_code;
                rpt_timer_q  <= 32'(REPEAT_DELAY - 1);
            end else if (scan_push && !scan_press && scan_code == rpt_code_q) begin
                // Stop even if the release itself was dropped, so a lost release
                // cannot leave the key repeating forever.
                rpt_active_q <= 1'b0;
            end else if (rpt_fire) begin
                // Reload whether or not the repeat fitted; a dropped repeat is lost.
                rpt_timer_q <= 32'(REPEAT_RATE - 1);
            end else if (rpt_active_q && rpt_timer_q != '0) begin
                rpt_timer_q <= rpt_timer_q - 1'b1;
            end
        end
    end

    assign evt_repeat = empty ? 1'b0 : mem_rpt[rd_ptr_q];
`else
    assign push_req   = scan_push;
    assign push_code  = scan_code;
    assign push_press = scan_press;
    assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (KEY_W=8, NUM_KEYS=6, DEPTH=8; repeat timing
// 20/5 when KEY_EVT_REPEAT_EN is defined). Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point.

module tb_key_event_queue;

    localparam int unsigned KEY_W    = 8;
    localparam int unsigned NUM_KEYS = 6;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_KEYS*KEY_W-1:0] report_in = '0;
    logic                      report_wr = 1'b0;
    logic                      evt_ready = 1'b0;
    logic                      ovf_clr = 1'b0;
    logic                      busy;
    logic                      evt_valid;
    logic [KEY_W-1:0]          evt_code;
    logic                      evt_press;
    logic                      evt_repeat;
    logic [CNT_W-1:0]          count;
    logic                      overflow;

    int n_assert = 0;
    int n_fail   = 0;

    key_event_queue #(
        .KEY_W        (KEY_W),
        .NUM_KEYS     (NUM_KEYS),
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .report_in     (report_in),
        .report_wr     (report_wr),
        .busy          (busy),
        .evt_valid     (evt_valid),
        .evt_code      (evt_code),
        .evt_press     (evt_press),
        .evt_repeat    (evt_repeat),
        .evt_ready     (evt_ready),
        .count         (count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NUM_KEYS*KEY_W-1:0] r);
        report_in = r;
        report_wr = 1'b1;
        tick();
        report_wr = 1'b0;
    endtask

    // Counts sampled busy cycles; bounded so a stuck FSM shows up as a bad count.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        report_wr = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_head(input string tag, input logic [7:0] code, input logic press,
                            input logic rpt);
        chk({tag, " code"}, evt_code, code);
        chk({tag, " press"}, evt_press, press);
        chk({tag, " repeat"}, evt_repeat, rpt);
    endtask

    initial begin
        int n;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst busy", busy, 0);
        chk("rst valid", evt_valid, 0);
        chk("rst count", count, 0);
        chk("rst overflow", overflow, 0);
        chk_head("rst head", 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single key: 13-cycle scan, one press
        send(48'h00_00_00_00_00_04);
        wait_idle(n);
        chk("scan length", n, 13);
        chk("p1 count", count, 1);
        chk("p1 valid", evt_valid, 1);
        chk_head("p1 head", 8'h04, 1'b1, 1'b0);
`ifdef KEY_EVT_REPEAT_EN
        // Press was stored at edge 7 of the scan; repeats due at edges 27, 32, 37.
        repeat (13) tick();
        chk("rpt before delay", count, 1);
        tick();
        chk("rpt first", count, 2);
        pop();
        chk_head("rpt head", 8'h04, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rpt before rate", count, 1);
        tick();
        chk("rpt second", count, 2);
        repeat (5) tick();
        chk("rpt third", count, 3);
        send(48'h0);
        repeat (40) tick();
        chk("rpt stopped", count, 4);
        pop();
        pop();
        pop();
        chk_head("rpt release", 8'h04, 1'b0, 1'b0);
        chk("rpt release count", count, 1);
`else
        repeat (40) tick();
        chk("no repeat count", count, 1);
        chk("no repeat flag", evt_repeat, 0);
`endif

        // Order: press 0x16, then release 0x04 (second report queued as pending)
        do_reset();
        chk("reset clears count", count, 0);
        chk("reset clears valid", evt_valid, 0);
        send(48'h00_00_00_00_00_04);
        wait_idle(n);
        pop();
        chk("drained count", count, 0);
        chk_head("empty head", 8'h00, 1'b0, 1'b0);
        send(48'h00_00_00_00_16_04);
        send(48'h00_00_00_00_16_00);
        wait_idle(n);
        chk("two scan length", n, 25);
        chk("order count", count, 2);
        chk_head("order first", 8'h16, 1'b1, 1'b0);
        pop();
        chk_head("order second", 8'h04, 1'b0, 1'b0);
        chk("order count after pop", count, 1);

        // Duplicate code inside one report
        do_reset();
        send(48'h04_04_00_00_00_00);
        wait_idle(n);
        chk("dup count", count, 1);
        chk_head("dup head", 8'h04, 1'b1, 1'b0);
        pop();
        chk("dup drained", evt_valid, 0);

        // Three strobes in one scan: A scanned, B discarded, C scanned against A
        do_reset();
        send(48'h00_00_00_00_00_04);
        send(48'h00_00_00_00_00_05);
        send(48'h00_00_00_00_00_06);
        wait_idle(n);
        chk("abc busy", n, 24);
        chk("abc count", count, 3);
        chk_head("abc e0", 8'h04, 1'b1, 1'b0);
        pop();
        chk_head("abc e1", 8'h04, 1'b0, 1'b0);
        pop();
        chk_head("abc e2", 8'h06, 1'b1, 1'b0);
        pop();
        chk("abc drained", count, 0);

        // Overflow: 6 presses + 6 releases into 8 entries
        do_reset();
        send(48'h16_15_14_13_12_11);
        wait_idle(n);
        chk("ovf six", count, 6);
        chk("ovf not yet", overflow, 0);
        send(48'h0);
        wait_idle(n);
        chk("ovf full count", count, 8);
        chk("ovf set", overflow, 1);
        chk_head("ovf head", 8'h11, 1'b1, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf cleared", overflow, 0);
        chk("ovf clr keeps count", count, 8);
        // Press 0x11 lands in PRS slot 0 (7th scan cycle); pop in that same cycle.
        send(48'h00_00_00_00_00_11);
        repeat (6) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("full push+pop count", count, 8);
        chk("full push+pop no ovf", overflow, 0);
        chk_head("full push+pop head", 8'h12, 1'b1, 1'b0);
        wait_idle(n);
        // Release 0x11 dropped in the first scan cycle while ovf_clr is high
        send(48'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("set beats clr", overflow, 1);
        wait_idle(n);
        chk("still full", count, 8);
        repeat (7) pop();
        chk("tail count", count, 1);
        chk_head("tail entry", 8'h11, 1'b1, 1'b0);
        pop();
        chk("final empty", evt_valid, 0);
        chk("final count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
